block_frame_ctrl: RTL and testbench

//  Frame-level sequencer for the falling-block playfield; sits directly upstream of the block

---
 rtl/block_frame_ctrl_if.sv | 31 +++
 rtl/block_frame_ctrl.sv | 159 +++++++++++++++
 tb/tb_block_frame_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/block_frame_ctrl_if.sv
// Handshake and draw-path bundle between the frame sequencer and the playfield datapath.
// The sequencer drives the strobes (master); the playfield/VGA side consumes them (slave).
interface block_frame_ctrl_if #(
    parameter int unsigned NUM_BLK = 10
);
    localparam int unsigned SEL_W = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;

    logic               go;
    logic               stop;
    logic [NUM_BLK-1:0] ld_blk;
    logic               move_en;
    logic [SEL_W-1:0]   blk_sel;
    logic [4:0]         pix_x_off;
    logic [4:0]         pix_y_off;
    logic               erase;
    logic               plot;
    logic               busy;
    logic               overrun;

    modport master (
        input  go, stop,
        output ld_blk, move_en, blk_sel, pix_x_off, pix_y_off,
               erase, plot, busy, overrun
    );

    modport slave (
        output go, stop,
        input  ld_blk, move_en, blk_sel, pix_x_off, pix_y_off,
               erase, plot, busy, overrun
    );
endinterface

// File: rtl/block_frame_ctrl.sv
// Frame-level sequencer: per game step erases all slots, pulses move, optionally spawns,
// then redraws all slots, emitting one VGA plot strobe per pixel.
module block_frame_ctrl #(
    parameter int unsigned NUM_BLK         = 10,
    parameter int unsigned BLK_SIZE        = 20,
    parameter int unsigned FRAME_TICKS     = 833334,
    parameter int unsigned FRAMES_PER_STEP = 15,
    parameter int unsigned SPAWN_EVERY     = 4
) (
    input  logic                clock,
    input  logic                reset,
    block_frame_ctrl_if.master  bus
);
    localparam int unsigned SEL_W = (NUM_BLK > 1)         ? $clog2(NUM_BLK)         : 1;
    localparam int unsigned TMR_W = (FRAME_TICKS > 1)     ? $clog2(FRAME_TICKS)     : 1;
    localparam int unsigned FRM_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int unsigned STP_W = (SPAWN_EVERY > 1)     ? $clog2(SPAWN_EVERY)     : 1;
    localparam int unsigned PIX_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FRAME,
        S_ERASE,
        S_MOVE,
        S_SPAWN,
        S_DRAW
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [FRM_W-1:0]   frm_q, frm_d;
    logic [STP_W-1:0]   stp_q, stp_d;
    logic [SEL_W-1:0]   blk_q, blk_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [PIX_W-1:0]   x_q, x_d;
    logic [PIX_W-1:0]   y_q, y_d;
    logic               ovr_q, ovr_d;

    logic tick;
    logic in_pass;
    logic x_last, y_last, b_last, last_pix;
    logic spawn_fire;

    assign tick       = (state_q != S_IDLE) && (tmr_q == TMR_W'(FRAME_TICKS - 1));
    assign in_pass    = (state_q == S_ERASE) || (state_q == S_DRAW);
    assign x_last     = (x_q == PIX_W'(BLK_SIZE - 1));
    assign y_last     = (y_q == PIX_W'(BLK_SIZE - 1));
    assign b_last     = (blk_q == SEL_W'(NUM_BLK - 1));
    assign last_pix   = x_last && y_last && b_last;
    assign spawn_fire = (state_q == S_SPAWN) && (stp_q == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            frm_q   <= '0;
            stp_q   <= '0;
            blk_q   <= '0;
            ptr_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            frm_q   <= frm_d;
            stp_q   <= stp_d;
            blk_q   <= blk_d;
            ptr_q   <= ptr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.stop) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:       if (bus.go) state_d = S_WAIT_FRAME;
                S_WAIT_FRAME: if (tick && (frm_q == FRM_W'(FRAMES_PER_STEP - 1))) state_d = S_ERASE;
                S_ERASE:      if (last_pix) state_d = S_MOVE;
                S_MOVE:       state_d = S_SPAWN;
                S_SPAWN:      state_d = S_DRAW;
                S_DRAW:       if (last_pix) state_d = S_WAIT_FRAME;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    // Counters are zeroed both while idle and on the cycle that enters idle, so a stop
    // never leaves a stale timer value able to raise a tick outside WAIT_FRAME.
    always_comb begin
        tmr_d = tmr_q;
        frm_d = frm_q;
        stp_d = stp_q;
        blk_d = blk_q;
        x_d   = x_q;
        y_d   = y_q;
        ptr_d = ptr_q;
        ovr_d = ovr_q;

        if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
            tmr_d = '0;
            frm_d = '0;
            stp_d = '0;
            blk_d = '0;
            x_d   = '0;
            y_d   = '0;
        end else begin
            tmr_d = tick ? '0 : tmr_q + 1'b1;

            if ((state_q == S_WAIT_FRAME) && tick) begin
                frm_d = (frm_q == FRM_W'(FRAMES_PER_STEP - 1)) ? '0 : frm_q + 1'b1;
            end

            if (in_pass) begin
                if (x_last) begin
                    x_d = '0;
                    if (y_last) begin
                        y_d = '0;
                        blk_d = b_last ? '0 : blk_q + 1'b1;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end

            if (state_q == S_SPAWN) begin
                stp_d = (stp_q == STP_W'(SPAWN_EVERY - 1)) ? '0 : stp_q + 1'b1;
            end
        end

        if (spawn_fire) begin
            ptr_d = (ptr_q == SEL_W'(NUM_BLK - 1)) ? '0 : ptr_q + 1'b1;
        end

        if (tick && (state_q != S_WAIT_FRAME)) begin
            ovr_d = 1'b1;
        end
    end

    always_comb begin
        bus.plot      = in_pass;
        bus.erase     = (state_q == S_ERASE);
        bus.move_en   = (state_q == S_MOVE);
        bus.busy      = (state_q == S_ERASE) || (state_q == S_MOVE) ||
                        (state_q == S_SPAWN) || (state_q == S_DRAW);
        bus.ld_blk    = spawn_fire ? (NUM_BLK'(1) << ptr_q) : '0;
        bus.blk_sel   = in_pass ? blk_q : '0;
        bus.pix_x_off = in_pass ? x_q : '0;
        bus.pix_y_off = in_pass ? y_q : '0;
        bus.overrun   = ovr_q;
    end
endmodule

// File: tb/tb_block_frame_ctrl.sv
// Scoreboard bench for block_frame_ctrl: expected strobe events are queued with their
// cycle numbers when stimulus is applied and matched against every active output cycle.
module tb_block_frame_ctrl;
    localparam int unsigned NB  = 2;
    localparam int unsigned BS  = 2;
    localparam int unsigned FT  = 32;
    localparam int unsigned FPS = 2;
    localparam int unsigned SE  = 2;
    localparam int unsigned PASS_LEN = NB * BS * BS;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc   = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    typedef struct {
        int unsigned cyc;
        logic [31:0] desc;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         mon_e;
    logic [31:0] mon_d;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    block_frame_ctrl_if #(.NUM_BLK(NB)) bus ();
    block_frame_ctrl_if #(.NUM_BLK(NB)) bus2 ();

    block_frame_ctrl #(
        .NUM_BLK(NB), .BLK_SIZE(BS), .FRAME_TICKS(FT),
        .FRAMES_PER_STEP(FPS), .SPAWN_EVERY(SE)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    block_frame_ctrl #(
        .NUM_BLK(NB), .BLK_SIZE(BS), .FRAME_TICKS(8),
        .FRAMES_PER_STEP(FPS), .SPAWN_EVERY(SE)
    ) dut_ov (
        .clock(clock), .reset(reset), .bus(bus2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk(input int unsigned pl, input int unsigned er,
                                       input int unsigned mv, input int unsigned ld,
                                       input int unsigned sel, input int unsigned x,
                                       input int unsigned y);
        return (pl << 24) | (er << 20) | (mv << 16) | (ld << 12) | (sel << 8) | (x << 4) | y;
    endfunction

    task automatic push(input int unsigned c, input int unsigned cutoff, input logic [31:0] d);
        if (c < cutoff) exp_q.push_back('{c, d});
    endtask

    // Timeline model: step s starts erasing right after frame tick FPS*(s+1), since the
    // frame timer keeps running through the pass.
    task automatic gen(input int unsigned t0, input int unsigned nsteps,
                       input int unsigned ptr0, input int unsigned cutoff);
        int unsigned ptr;
        int unsigned e;
        ptr = ptr0;
        for (int unsigned s = 0; s < nsteps; s++) begin
            e = t0 + FT * FPS * (s + 1);
            for (int unsigned k = 0; k < PASS_LEN; k++)
                push(e + k, cutoff, mk(1, 1, 0, 0, k / (BS * BS), k % BS, (k / BS) % BS));
            push(e + PASS_LEN, cutoff, mk(0, 0, 1, 0, 0, 0, 0));
            if ((s % SE) == 0) begin
                push(e + PASS_LEN + 1, cutoff, mk(0, 0, 0, 1 << ptr, 0, 0, 0));
                ptr = (ptr + 1) % NB;
            end
            for (int unsigned k = 0; k < PASS_LEN; k++)
                push(e + PASS_LEN + 2 + k, cutoff, mk(1, 0, 0, 0, k / (BS * BS), k % BS, (k / BS) % BS));
        end
    endtask

    always @(negedge clock) begin
        if (!reset && (bus.plot || bus.move_en || (bus.ld_blk != '0))) begin
            mon_d = mk(bus.plot, bus.erase, bus.move_en, bus.ld_blk,
                       bus.blk_sel, bus.pix_x_off, bus.pix_y_off);
            check("mv_ld_excl", bus.move_en && (bus.ld_blk != '0), 0);
            check("ld_onehot", $countones(bus.ld_blk) > 1, 0);
            if (exp_q.size() == 0) begin
                check("spurious_out", mon_d, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ev_cyc", cyc, mon_e.cyc);
                check("ev_val", mon_d, mon_e.desc);
            end
        end
    end

    initial begin
        int unsigned t0;
        int unsigned ov_cyc;
        int unsigned moves;
        bit          ov_seen;

        bus.go = 1'b0;  bus.stop = 1'b0;
        bus2.go = 1'b0; bus2.stop = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_plot", bus.plot, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ld", bus.ld_blk, 0);
        check("rst_move", bus.move_en, 0);
        check("rst_ovr", bus.overrun, 0);
        check("rst_sel", bus.blk_sel, 0);
        check("rst_xy", {bus.pix_x_off, bus.pix_y_off}, 0);
        reset = 1'b0;

        // Short frame: an 18-cycle pass overlaps the tick at ERASE's last cycle.
        @(negedge clock);
        bus2.go = 1'b1;
        t0 = cyc + 1;
        @(negedge clock);
        bus2.go = 1'b0;
        check("ov_wait_busy", bus2.busy, 0);
        check("ov_clear", bus2.overrun, 0);
        ov_seen = 1'b0;
        ov_cyc  = 0;
        for (int i = 0; i < 200 && !ov_seen; i++) begin
            @(negedge clock);
            if (bus2.overrun) begin
                ov_seen = 1'b1;
                ov_cyc  = cyc;
            end
        end
        check("ov_set", ov_seen, 1);
        check("ov_cyc", ov_cyc, t0 + 24);
        moves = 0;
        repeat (100) begin
            @(negedge clock);
            if (bus2.move_en) moves++;
        end
        check("ov_continues", moves > 0, 1);
        check("ov_sticky", bus2.overrun, 1);
        bus2.stop = 1'b1;

        // Five steps, then stop three beats into the fifth DRAW pass.
        @(negedge clock);
        bus.go = 1'b1;
        t0 = cyc + 1;
        gen(t0, 5, 0, t0 + FT * FPS * 5 + PASS_LEN + 2 + 3);
        @(negedge clock);
        bus.go = 1'b0;
        check("wait_busy", bus.busy, 0);
        while (cyc < t0 + FT * FPS) @(negedge clock);
        check("erase_busy", bus.busy, 1);
        while (cyc < t0 + FT * FPS * 5 + PASS_LEN + 2 + 2) @(negedge clock);
        bus.stop = 1'b1;
        @(negedge clock);
        check("stop_plot", bus.plot, 0);
        check("stop_busy", bus.busy, 0);
        bus.go = 1'b1;
        repeat (5) @(negedge clock);
        check("go_stop_idle", bus.busy | bus.plot, 0);
        check("stop_drain", exp_q.size(), 0);

        // Restart keeps spawn_ptr (next spawn is slot 1); reset lands mid-ERASE.
        bus.stop = 1'b0;
        t0 = cyc + 1;
        gen(t0, 1, 1, t0 + FT * FPS + 4);
        @(negedge clock);
        bus.go = 1'b0;
        while (cyc < t0 + FT * FPS + 3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst_plot", bus.plot, 0);
        check("arst_erase", bus.erase, 0);
        check("arst_sel", bus.blk_sel, 0);
        check("arst_xy", {bus.pix_x_off, bus.pix_y_off}, 0);
        check("arst_busy", bus.busy, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (60) @(negedge clock);
        check("post_rst_idle", bus.busy, 0);
        check("rst_drain", exp_q.size(), 0);

        // After reset spawn_ptr is back to slot 0.
        bus.go = 1'b1;
        t0 = cyc + 1;
        gen(t0, 1, 0, t0 + FT * FPS + 2 * PASS_LEN + 2);
        @(negedge clock);
        bus.go = 1'b0;
        while (cyc < t0 + FT * FPS + 2 * PASS_LEN + 6) @(negedge clock);
        check("final_drain", exp_q.size(), 0);
        check("main_no_ovr", bus.overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
